// File: rtl/issue_control.sv
// Single-issue decode/issue stage: classifies the instruction, tracks in-flight
// producers in a shift scoreboard, and emits a registered control bundle.
module issue_control #(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned LOAD_LAT   = 2,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned REG_AW     = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic              issue_valid_o,
    output logic              rs1_re_o,
    output logic              rs2_re_o,
    output logic              rd_we_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [2:0]        fwd_rs1_o,
    output logic [2:0]        fwd_rs2_o,
    output logic              illegal_o
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic dec_rs1_re, dec_rs2_re, dec_rd_we, dec_mem_re, dec_mem_we, dec_illegal;
    logic hazard;
    logic [2:0] fwd_rs1, fwd_rs2;

    logic [PIPE_DEPTH-1:0] sb_valid_q, sb_valid_d;
    logic [PIPE_DEPTH-1:0] sb_load_q, sb_load_d;
    logic [REG_AW-1:0]     sb_rd_q [PIPE_DEPTH];
    logic [REG_AW-1:0]     sb_rd_d [PIPE_DEPTH];

    logic       issue_valid_q, issue_valid_d;
    logic       rs1_re_q, rs1_re_d, rs2_re_q, rs2_re_d, rd_we_q, rd_we_d;
    logic       mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [2:0] fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;
    logic       illegal_q, illegal_d;

    always_comb begin
        dec_rs1_re  = 1'b0;
        dec_rs2_re  = 1'b0;
        dec_rd_we   = 1'b0;
        dec_mem_re  = 1'b0;
        dec_mem_we  = 1'b0;
        dec_illegal = 1'b0;
        case (opcode_i)
            OPC_OPIMM: begin
                dec_rs1_re = 1'b1;
                dec_rd_we  = 1'b1;
                if (funct3_i == 3'b001 && funct7_i != 7'b0000000)
                    dec_illegal = 1'b1;
                if (funct3_i == 3'b101 && funct7_i != 7'b0000000 && funct7_i != 7'b0100000)
                    dec_illegal = 1'b1;
            end
            OPC_OP: begin
                dec_rs1_re = 1'b1;
                dec_rs2_re = 1'b1;
                dec_rd_we  = 1'b1;
                if (funct7_i != 7'b0000000 && funct7_i != 7'b0100000)
                    dec_illegal = 1'b1;
                else if (funct7_i == 7'b0100000 && funct3_i != 3'b000 && funct3_i != 3'b101)
                    dec_illegal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                dec_rd_we = 1'b1;
            end
            OPC_LOAD: begin
                dec_rs1_re = 1'b1;
                dec_rd_we  = 1'b1;
                dec_mem_re = 1'b1;
                if (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111)
                    dec_illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_rs1_re = 1'b1;
                dec_rs2_re = 1'b1;
                dec_mem_we = 1'b1;
                if (funct3_i > 3'b010)
                    dec_illegal = 1'b1;
            end
            OPC_JALR: begin
                dec_rs1_re = 1'b1;
                dec_rd_we  = 1'b1;
            end
            OPC_BRANCH: begin
                dec_rs1_re = 1'b1;
                dec_rs2_re = 1'b1;
                if (funct3_i == 3'b010 || funct3_i == 3'b011)
                    dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_rs1_re = 1'b0;
            dec_rs2_re = 1'b0;
            dec_rd_we  = 1'b0;
            dec_mem_re = 1'b0;
            dec_mem_we = 1'b0;
        end
        if (rd_i == '0)
            dec_rd_we = 1'b0;
    end

    // Ascending scan: first match is the youngest producer, so it wins the forward select.
    always_comb begin
        hazard  = 1'b0;
        fwd_rs1 = '0;
        fwd_rs2 = '0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (dec_rs1_re && rs1_i != '0 && sb_valid_q[i] && sb_rd_q[i] == rs1_i) begin
                if (!FWD_EN || (sb_load_q[i] && (i + 1) <= (LOAD_LAT - 1)))
                    hazard = 1'b1;
                if (FWD_EN && fwd_rs1 == '0)
                    fwd_rs1 = 3'(i + 1);
            end
            if (dec_rs2_re && rs2_i != '0 && sb_valid_q[i] && sb_rd_q[i] == rs2_i) begin
                if (!FWD_EN || (sb_load_q[i] && (i + 1) <= (LOAD_LAT - 1)))
                    hazard = 1'b1;
                if (FWD_EN && fwd_rs2 == '0)
                    fwd_rs2 = 3'(i + 1);
            end
        end
    end

    assign ready_o = valid_i && !hazard && !flush_i;

    // Entries without a register write never enter the scoreboard as valid.
    always_comb begin
        sb_valid_d    = '0;
        sb_load_d     = '0;
        sb_valid_d[0] = ready_o && dec_rd_we;
        sb_load_d[0]  = dec_mem_re;
        sb_rd_d[0]    = rd_i;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            sb_valid_d[i] = sb_valid_q[i-1] && !(i == 1 && flush_i);
            sb_load_d[i]  = sb_load_q[i-1];
            sb_rd_d[i]    = sb_rd_q[i-1];
        end
    end

    always_comb begin
        issue_valid_d = ready_o && !dec_illegal;
        rs1_re_d      = ready_o && dec_rs1_re;
        rs2_re_d      = ready_o && dec_rs2_re;
        rd_we_d       = ready_o && dec_rd_we;
        mem_re_d      = ready_o && dec_mem_re;
        mem_we_d      = ready_o && dec_mem_we;
        fwd_rs1_d     = (ready_o && dec_rs1_re) ? fwd_rs1 : '0;
        fwd_rs2_d     = (ready_o && dec_rs2_re) ? fwd_rs2 : '0;
        illegal_d     = ready_o && dec_illegal;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_valid_q    <= '0;
            sb_load_q     <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                sb_rd_q[i] <= '0;
            issue_valid_q <= 1'b0;
            rs1_re_q      <= 1'b0;
            rs2_re_q      <= 1'b0;
            rd_we_q       <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            fwd_rs1_q     <= '0;
            fwd_rs2_q     <= '0;
            illegal_q     <= 1'b0;
        end else begin
            sb_valid_q    <= sb_valid_d;
            sb_load_q     <= sb_load_d;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                sb_rd_q[i] <= sb_rd_d[i];
            issue_valid_q <= issue_valid_d;
            rs1_re_q      <= rs1_re_d;
            rs2_re_q      <= rs2_re_d;
            rd_we_q       <= rd_we_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            fwd_rs1_q     <= fwd_rs1_d;
            fwd_rs2_q     <= fwd_rs2_d;
            illegal_q     <= illegal_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign rs1_re_o      = rs1_re_q;
    assign rs2_re_o      = rs2_re_q;
    assign rd_we_o       = rd_we_q;
    assign mem_re_o      = mem_re_q;
    assign mem_we_o      = mem_we_q;
    assign fwd_rs1_o     = fwd_rs1_q;
    assign fwd_rs2_o     = fwd_rs2_q;
    assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_issue_control.sv
// Directed bench for issue_control: forwarding, load-use stalls, illegal
// decode, flush and mid-stall reset on a forwarding and a non-forwarding instance.
module tb_issue_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic       valid, valid2, flush;

    logic       ready, issue_valid, rs1_re, rs2_re, rd_we, mem_re, mem_we, illegal;
    logic [2:0] fwd1, fwd2;
    logic       ready2, issue_valid2, rs1_re2, rs2_re2, rd_we2, mem_re2, mem_we2, illegal2;
    logic [2:0] fwd1_2, fwd2_2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issue_control #(.PIPE_DEPTH(3), .LOAD_LAT(2), .FWD_EN(1'b1), .REG_AW(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .valid_i(valid), .ready_o(ready), .flush_i(flush),
        .issue_valid_o(issue_valid), .rs1_re_o(rs1_re), .rs2_re_o(rs2_re), .rd_we_o(rd_we),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2),
        .illegal_o(illegal)
    );

    issue_control #(.PIPE_DEPTH(3), .LOAD_LAT(2), .FWD_EN(1'b0), .REG_AW(5)) dut_nofwd (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .valid_i(valid2), .ready_o(ready2), .flush_i(flush),
        .issue_valid_o(issue_valid2), .rs1_re_o(rs1_re2), .rs2_re_o(rs2_re2), .rd_we_o(rd_we2),
        .mem_re_o(mem_re2), .mem_we_o(mem_we2), .fwd_rs1_o(fwd1_2), .fwd_rs2_o(fwd2_2),
        .illegal_o(illegal2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
        opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = d;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
    } ill_vec_t;

    ill_vec_t ill_tab[8];

    initial begin
        ill_tab[0] = '{7'b0000011, 3'b011, 7'h00, 1'b1};
        ill_tab[1] = '{7'b0100011, 3'b011, 7'h00, 1'b1};
        ill_tab[2] = '{7'b1100011, 3'b010, 7'h00, 1'b1};
        ill_tab[3] = '{7'b0110011, 3'b001, 7'h20, 1'b1};
        ill_tab[4] = '{7'b0110011, 3'b000, 7'h20, 1'b0};
        ill_tab[5] = '{7'b0010011, 3'b001, 7'h01, 1'b1};
        ill_tab[6] = '{7'b0010011, 3'b101, 7'h20, 1'b0};
        ill_tab[7] = '{7'b1100011, 3'b000, 7'h00, 1'b0};

        rst_n = 1'b0; valid = 1'b0; valid2 = 1'b0; flush = 1'b0;
        drive(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3);
        #3;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_fwd1", fwd1, 0);
        valid = 1'b1;
        #1;
        check("rst_ready_empty_sb", ready, 1);
        valid = 1'b0;
        #8;
        rst_n = 1'b1;
        tick();

        // ADD x3,x1,x2 ; ADD x4,x3,x1 back-to-back
        drive(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3);
        valid = 1'b1;
        #1 check("add1_ready", ready, 1);
        tick();
        check("add1_issue_valid", issue_valid, 1);
        check("add1_rs2_re", rs2_re, 1);
        check("add1_rd_we", rd_we, 1);
        check("add1_mem_re", mem_re, 0);
        drive(7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd4);
        #1 check("add2_ready", ready, 1);
        tick();
        check("add2_issue_valid", issue_valid, 1);
        check("add2_fwd1", fwd1, 1);
        check("add2_fwd2", fwd2, 0);

        // LW x5 ; ADDI x6,x5,1 -> one bubble then forward from stage 2
        drive(7'b0000011, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5);
        #1 check("lw_ready", ready, 1);
        tick();
        check("lw_mem_re", mem_re, 1);
        check("lw_rd_we", rd_we, 1);
        drive(7'b0010011, 3'b000, 7'h00, 5'd5, 5'd0, 5'd6);
        #1 check("lu_stall_ready", ready, 0);
        tick();
        check("lu_bubble", issue_valid, 0);
        check("lu_bubble_rd_we", rd_we, 0);
        check("lu_release_ready", ready, 1);
        tick();
        check("lu_issue_valid", issue_valid, 1);
        check("lu_fwd1", fwd1, 2);
        check("lu_rs2_re", rs2_re, 0);

        // unknown opcode -> illegal pulse, no scoreboard entry
        drive(7'b1111111, 3'b000, 7'h00, 5'd8, 5'd8, 5'd8);
        #1 check("ill_ready", ready, 1);
        tick();
        check("ill_pulse", illegal, 1);
        check("ill_issue_valid", issue_valid, 0);
        check("ill_rd_we", rd_we, 0);
        drive(7'b0110011, 3'b000, 7'h00, 5'd8, 5'd8, 5'd9);
        #1 check("post_ill_ready", ready, 1);
        tick();
        check("ill_pulse_end", illegal, 0);
        check("post_ill_issue", issue_valid, 1);
        check("post_ill_fwd1", fwd1, 0);
        check("post_ill_fwd2", fwd2, 0);

        // funct3/funct7 legality table (x0 operands avoid hazards)
        foreach (ill_tab[i]) begin
            drive(ill_tab[i].op, ill_tab[i].f3, ill_tab[i].f7, 5'd0, 5'd0, 5'd0);
            tick();
            check($sformatf("tab%0d_illegal", i), illegal, ill_tab[i].ill);
            check($sformatf("tab%0d_issue", i), issue_valid, !ill_tab[i].ill);
        end

        // flush during a load-use stall kills the load entry
        valid = 1'b0;
        repeat (3) tick();
        drive(7'b0000011, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5);
        valid = 1'b1;
        tick();
        drive(7'b0010011, 3'b000, 7'h00, 5'd5, 5'd0, 5'd6);
        flush = 1'b1;
        #1 check("flush_ready", ready, 0);
        tick();
        check("flush_bubble", issue_valid, 0);
        flush = 1'b0;
        #1 check("post_flush_ready", ready, 1);
        tick();
        check("post_flush_issue", issue_valid, 1);
        check("post_flush_fwd1", fwd1, 0);

        // x0 destination and x0 sources
        valid = 1'b0;
        repeat (3) tick();
        drive(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0);
        valid = 1'b1;
        tick();
        check("x0_rd_we", rd_we, 0);
        check("x0_issue", issue_valid, 1);
        drive(7'b0110011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd2);
        #1 check("x0_src_ready", ready, 1);
        tick();
        check("x0_src_fwd1", fwd1, 0);
        check("x0_src_fwd2", fwd2, 0);
        check("x0_src_rd_we", rd_we, 1);

        // reset pulse mid-stall
        drive(7'b0000011, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5);
        tick();
        drive(7'b0010011, 3'b000, 7'h00, 5'd5, 5'd0, 5'd6);
        #1 check("rst_mid_stall_ready", ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_issue_valid", issue_valid, 0);
        check("rst_mid_mem_re", mem_re, 0);
        check("rst_mid_rd_we", rd_we, 0);
        check("rst_mid_ready", ready, 1);
        #1 rst_n = 1'b1;
        #1 check("post_rst_ready", ready, 1);
        tick();
        check("post_rst_issue", issue_valid, 1);
        check("post_rst_fwd1", fwd1, 0);

        // non-forwarding instance: LW x5 ; ADDI x6,x5,1 -> three bubbles
        valid = 1'b0;
        repeat (3) tick();
        drive(7'b0000011, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5);
        valid2 = 1'b1;
        #1 check("nf_lw_ready", ready2, 1);
        tick();
        check("nf_lw_issue", issue_valid2, 1);
        drive(7'b0010011, 3'b000, 7'h00, 5'd5, 5'd0, 5'd6);
        for (int k = 1; k <= 3; k++) begin
            #1 check($sformatf("nf_stall%0d_ready", k), ready2, 0);
            tick();
            check($sformatf("nf_bubble%0d", k), issue_valid2, 0);
        end
        #1 check("nf_release_ready", ready2, 1);
        tick();
        check("nf_issue", issue_valid2, 1);
        check("nf_fwd1", fwd1_2, 0);
        valid2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
